// File: rtl/uart_pkg.sv
// Shared definitions for the serial receiver: parity encodings, FSM states, frame width.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_ODD      = 2'b01;
    localparam logic [1:0] PARITY_EVEN     = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] pt);
        return (pt == PARITY_ODD) || (pt == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/rx_sampler.sv
// Line front end: 2-flop synchronizer, falling-edge detect and bit-value selection.
// SIPO_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over the last three synchronized samples.
module rx_sampler (
    input  logic baud_clk,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall,
    output logic o_bit
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rx_s = r_sync2;
    assign o_fall = r_prev & ~r_sync2;

`ifdef SIPO_RX_MAJORITY_VOTE_EN
    logic r_prev2;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev2 <= 1'b1;
        end else begin
            r_prev2 <= r_prev;
        end
    end

    // Current, previous and second-previous samples cover ticks mid+1, mid, mid-1.
    assign o_bit = (r_sync2 & r_prev) | (r_sync2 & r_prev2) | (r_prev & r_prev2);
`else
    assign o_bit = r_sync2;
`endif

endmodule

// File: rtl/sipo_rx.sv
// Oversampled serial receiver: framing FSM, LSB-first shift register and registered status.
// SIPO_RX_MAJORITY_VOTE_EN enables majority voting in rx_sampler (decisions one cycle later).
module sipo_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       baud_clk,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef SIPO_RX_MAJORITY_VOTE_EN
    // Only the start check moves; later bits stay aligned because tick restarts from it.
    localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 1);
`endif

    logic w_rx_s;
    logic w_fall;
    logic w_bit;

    rx_sampler u_rx_sampler (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .i_rx     (data_rx),
        .o_rx_s   (w_rx_s),
        .o_fall   (w_fall),
        .o_bit    (w_bit)
    );

    rx_state_e              r_state;
    logic [TW-1:0]          r_tick;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [1:0]             r_parity_type;
    logic                   r_parity_bad;
    logic                   r_need_high;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_tick        <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_parity_type <= PARITY_NONE;
            r_parity_bad  <= 1'b0;
            r_need_high   <= 1'b0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            stop_error    <= 1'b0;
            active_flag   <= 1'b0;
            done_flag     <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tick    <= '0;
                    r_bit_idx <= '0;
                    if (w_rx_s) begin
                        r_need_high <= 1'b0;
                    end
                    // A break leaves r_need_high set until the line is seen high again.
                    if (w_fall && !r_need_high) begin
                        r_state       <= START;
                        r_parity_type <= parity_type;
                        r_parity_bad  <= 1'b0;
                        active_flag   <= 1'b1;
                        done_flag     <= 1'b0;
                    end
                end
                START: begin
                    if (r_tick == TICK_START) begin
                        r_tick <= '0;
                        if (!w_bit) begin
                            r_state <= DATA;
                        end else begin
                            r_state     <= IDLE;
                            active_flag <= 1'b0;
                            done_flag   <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick    <= '0;
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BW'(1);
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= parity_enabled(r_parity_type) ? PARITY : STOP;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick       <= '0;
                        r_parity_bad <= ((^r_shift) ^ w_bit) != (r_parity_type == PARITY_ODD);
                        r_state      <= STOP;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick       <= '0;
                        data_out     <= r_shift;
                        parity_error <= r_parity_bad;
                        stop_error   <= ~w_bit;
                        r_need_high  <= ~w_bit;
                        data_valid   <= 1'b1;
                        active_flag  <= 1'b0;
                        done_flag    <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: directed frames push expected results, a monitor checks each pulse.
module tb_sipo_rx;

    localparam int OVS = 16;
    localparam int BIT = OVS * 10;

    logic       baud_clk = 1'b0;
    logic       reset_n;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    int checks   = 0;
    int failures = 0;

    // Each entry: {data_out, parity_error, stop_error}
    logic [9:0] exp_q[$];

    always #5 baud_clk = ~baud_clk;

    sipo_rx #(.OVERSAMPLE(OVS)) dut (
        .baud_clk     (baud_clk),
        .reset_n      (reset_n),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge baud_clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit has_par, input logic p,
                               input logic stop, input int bit_t, input int hold_low_bits,
                               input logic [1:0] pt_mid);
        data_rx = 1'b0;
        #(bit_t);
        if (bit_t == BIT) begin
            chk1("active_mid_frame", active_flag, 1'b1);
            chk1("done_mid_frame", done_flag, 1'b0);
        end
        parity_type = pt_mid;
        for (int i = 0; i < 8; i++) begin
            data_rx = b[i];
            #(bit_t);
        end
        if (has_par) begin
            data_rx = p;
            #(bit_t);
        end
        data_rx = stop;
        #(bit_t);
        if (hold_low_bits > 0) begin
            #(bit_t * hold_low_bits);
        end
        data_rx = 1'b1;
    endtask

    // Monitor: every data_valid cycle must match the oldest expected frame.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge baud_clk);
            if (reset_n === 1'b1 && data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: data_out=%h expected no data_valid", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk8("data_out", data_out, e[9:2]);
                    chk1("parity_error", parity_error, e[1]);
                    chk1("stop_error", stop_error, e[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b77;
        int         waited;
        int         skews[2];
        b77      = 8'h77;
        skews[0] = 155;
        skews[1] = 165;

        data_rx     = 1'b1;
        parity_type = 2'b00;
        reset_n     = 1'b0;
        idle(3);
        chk8("reset_data_out", data_out, 8'h00);
        chk1("reset_data_valid", data_valid, 1'b0);
        chk1("reset_parity_error", parity_error, 1'b0);
        chk1("reset_stop_error", stop_error, 1'b0);
        chk1("reset_active_flag", active_flag, 1'b0);
        chk1("reset_done_flag", done_flag, 1'b1);
        reset_n = 1'b1;
        idle(20);

        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        drive_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT, 0, 2'b00);
        idle(40);

        // Odd parity on 8'h03: parity bit 0 is wrong, 1 is right.
        parity_type = 2'b01;
        exp_q.push_back({8'h03, 1'b1, 1'b0});
        drive_frame(8'h03, 1'b1, 1'b0, 1'b1, BIT, 0, 2'b01);
        idle(40);
        chk1("parity_error_hold", parity_error, 1'b1);

        // parity_type flips to none mid-frame; the latched odd setting must still apply.
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        drive_frame(8'h03, 1'b1, 1'b1, 1'b1, BIT, 0, 2'b00);
        idle(40);

        // Even parity, stop bit low, then 30 bit times of break.
        parity_type = 2'b10;
        exp_q.push_back({8'h5A, 1'b0, 1'b1});
        drive_frame(8'h5A, 1'b1, 1'b0, 1'b0, BIT, 30, 2'b10);
        idle(40);
        chk1("stop_error_hold", stop_error, 1'b1);
        chk1("idle_after_break", active_flag, 1'b0);

        exp_q.push_back({8'h81, 1'b0, 1'b0});
        drive_frame(8'h81, 1'b1, 1'b0, 1'b1, BIT, 0, 2'b10);
        idle(40);

        // Short low glitch on an idle line.
        parity_type = 2'b00;
        data_rx = 1'b0;
        #(OVS / 4 * 10);
        data_rx = 1'b1;
        idle(40);
        chk1("glitch_active_flag", active_flag, 1'b0);
        chk1("glitch_done_flag", done_flag, 1'b1);

        // Reset in the middle of data bit 4.
        data_rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            data_rx = b77[i];
            #(BIT);
        end
        data_rx = b77[4];
        #(BIT / 2);
        reset_n = 1'b0;
        #20;
        chk8("midreset_data_out", data_out, 8'h00);
        chk1("midreset_data_valid", data_valid, 1'b0);
        chk1("midreset_parity_error", parity_error, 1'b0);
        chk1("midreset_stop_error", stop_error, 1'b0);
        chk1("midreset_active_flag", active_flag, 1'b0);
        chk1("midreset_done_flag", done_flag, 1'b1);
        data_rx = 1'b1;
        #40;
        reset_n = 1'b1;
        idle(40);
        chk1("post_reset_active_flag", active_flag, 1'b0);
        chk8("post_reset_data_out", data_out, 8'h00);

        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, BIT, 0, 2'b00);
        idle(40);

        // Back-to-back frames at roughly -3% and +3% bit-rate skew.
        for (int s = 0; s < 2; s++) begin
            @(negedge baud_clk);
            exp_q.push_back({8'h00, 1'b0, 1'b0});
            exp_q.push_back({8'hFF, 1'b0, 1'b0});
            drive_frame(8'h00, 1'b0, 1'b0, 1'b1, skews[s], 0, 2'b00);
            drive_frame(8'hFF, 1'b0, 1'b0, 1'b1, skews[s], 0, 2'b00);
            idle(40);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 5000) begin
            @(negedge baud_clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d frames still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
